// File: rtl/spi_txn_sequencer_if.sv
// rtl/spi_txn_sequencer_if.sv - command/stream/core-register bundle for the SPI transaction sequencer
interface spi_txn_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_ss;
    logic [7:0]  cmd_len;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        busy;
    logic        done;
    logic        err;
    logic        spi_select;
    logic        spi_read_n;
    logic        spi_write_n;
    logic [2:0]  spi_mem_addr;
    logic [15:0] spi_wdata;
    logic [15:0] spi_rdata;
    logic        spi_dataavailable;
    logic        spi_readyfordata;

    modport master (
        input  cmd_valid, cmd_ss, cmd_len, tx_data, tx_valid, rx_ready,
               spi_rdata, spi_dataavailable, spi_readyfordata,
        output cmd_ready, tx_ready, rx_data, rx_valid, busy, done, err,
               spi_select, spi_read_n, spi_write_n, spi_mem_addr, spi_wdata
    );

    modport slave (
        output cmd_valid, cmd_ss, cmd_len, tx_data, tx_valid, rx_ready,
               spi_rdata, spi_dataavailable, spi_readyfordata,
        input  cmd_ready, tx_ready, rx_data, rx_valid, busy, done, err,
               spi_select, spi_read_n, spi_write_n, spi_mem_addr, spi_wdata
    );
endinterface

// File: rtl/spi_txn_sequencer.sv
// rtl/spi_txn_sequencer.sv - burst SPI transaction engine owning the SPI core's register port
module spi_txn_sequencer #(
    parameter int TIMEOUT_CYC = 8192,
    parameter int TO_W        = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    spi_txn_sequencer_if.master  bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_CLR, S_SEL, S_SSON, S_TXW, S_RXW, S_RD, S_RXH, S_SSOFF, S_FIN
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    state_t          state;
    logic [1:0]      ph;
    logic [15:0]     ss_mask;
    logic [7:0]      remaining;
    logic [TO_W-1:0] to_cnt;
    logic            abort;

    logic [2:0]      acc_addr;
    logic [15:0]     acc_data;
    state_t          acc_next;

    // Fixed register writes: target address, data and successor state
    always_comb begin
        acc_addr = 3'd0;
        acc_data = 16'h0000;
        acc_next = S_IDLE;
        case (state)
            S_CLR:   begin acc_addr = 3'd2; acc_data = 16'h0000; acc_next = S_SEL;   end
            S_SEL:   begin acc_addr = 3'd5; acc_data = ss_mask;  acc_next = S_SSON;  end
            S_SSON:  begin acc_addr = 3'd3; acc_data = 16'h0400; acc_next = S_TXW;   end
            S_SSOFF: begin acc_addr = 3'd3; acc_data = 16'h0000; acc_next = S_FIN;   end
            default: begin acc_addr = 3'd0; acc_data = 16'h0000; acc_next = S_IDLE;  end
        endcase
    end

    // Each core access: ph 0 is the idle gap and launches the strobe, ph 1/2 are the two strobe cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= S_IDLE;
            ph               <= 2'd0;
            ss_mask          <= 16'h0000;
            remaining        <= 8'h00;
            to_cnt           <= '0;
            abort            <= 1'b0;
            bus.spi_select   <= 1'b0;
            bus.spi_read_n   <= 1'b1;
            bus.spi_write_n  <= 1'b1;
            bus.spi_mem_addr <= 3'd0;
            bus.spi_wdata    <= 16'h0000;
            bus.rx_valid     <= 1'b0;
            bus.rx_data      <= 8'h00;
            bus.tx_ready     <= 1'b0;
            bus.done         <= 1'b0;
            bus.err          <= 1'b0;
            bus.busy         <= 1'b0;
            bus.cmd_ready    <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        ss_mask       <= bus.cmd_ss;
                        remaining     <= bus.cmd_len;
                        bus.cmd_ready <= 1'b0;
                        bus.busy      <= 1'b1;
                        ph            <= 2'd0;
                        state         <= S_CLR;
                    end
                end

                S_CLR, S_SEL, S_SSON, S_SSOFF: begin
                    case (ph)
                        2'd0: begin
                            bus.spi_select   <= 1'b1;
                            bus.spi_write_n  <= 1'b0;
                            bus.spi_mem_addr <= acc_addr;
                            bus.spi_wdata    <= acc_data;
                            ph               <= 2'd1;
                        end
                        2'd1: ph <= 2'd2;
                        default: begin
                            bus.spi_select  <= 1'b0;
                            bus.spi_write_n <= 1'b1;
                            ph              <= 2'd0;
                            state           <= acc_next;
                            if (state == S_SSOFF) begin
                                bus.done <= 1'b1;
                                bus.err  <= abort;
                            end
                        end
                    endcase
                end

                S_TXW: begin
                    case (ph)
                        2'd0: begin
                            if (bus.tx_valid && bus.spi_readyfordata) begin
                                bus.spi_select   <= 1'b1;
                                bus.spi_write_n  <= 1'b0;
                                bus.spi_mem_addr <= 3'd1;
                                bus.spi_wdata    <= {8'h00, bus.tx_data};
                                bus.tx_ready     <= 1'b1;
                                ph               <= 2'd1;
                            end
                        end
                        2'd1: begin
                            bus.tx_ready <= 1'b0;
                            ph           <= 2'd2;
                        end
                        default: begin
                            bus.spi_select  <= 1'b0;
                            bus.spi_write_n <= 1'b1;
                            ph              <= 2'd0;
                            to_cnt          <= '0;
                            state           <= S_RXW;
                        end
                    endcase
                end

                S_RXW: begin
                    if (bus.spi_dataavailable) begin
                        ph    <= 2'd0;
                        state <= S_RD;
                    end else if (to_cnt == TO_LAST) begin
                        abort <= 1'b1;
                        ph    <= 2'd0;
                        state <= S_SSOFF;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end

                S_RD: begin
                    case (ph)
                        2'd0: begin
                            bus.spi_select   <= 1'b1;
                            bus.spi_read_n   <= 1'b0;
                            bus.spi_mem_addr <= 3'd0;
                            bus.spi_wdata    <= 16'h0000;
                            ph               <= 2'd1;
                        end
                        2'd1: ph <= 2'd2;
                        default: begin
                            bus.spi_select <= 1'b0;
                            bus.spi_read_n <= 1'b1;
                            bus.rx_data    <= bus.spi_rdata[7:0];
                            bus.rx_valid   <= 1'b1;
                            ph             <= 2'd0;
                            state          <= S_RXH;
                        end
                    endcase
                end

                S_RXH: begin
                    if (bus.rx_ready) begin
                        bus.rx_valid <= 1'b0;
                        ph           <= 2'd0;
                        if (remaining == 8'h00) begin
                            state <= S_SSOFF;
                        end else begin
                            remaining <= remaining - 8'h01;
                            state     <= S_TXW;
                        end
                    end
                end

                S_FIN: begin
                    bus.done      <= 1'b0;
                    bus.err       <= 1'b0;
                    abort         <= 1'b0;
                    bus.busy      <= 1'b0;
                    bus.cmd_ready <= 1'b1;
                    state         <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_txn_sequencer.sv
// tb/tb_spi_txn_sequencer.sv - randomized bench with SPI core model and transaction-level reference
module tb_spi_txn_sequencer;
    localparam int TO_CYC = 64;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    spi_txn_sequencer_if bus();

    spi_txn_sequencer #(.TIMEOUT_CYC(TO_CYC), .TO_W(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic        w;
        logic [2:0]  addr;
        logic [15:0] data;
    } acc_t;

    int   n_checks = 0;
    int   n_errors = 0;
    acc_t obs_q[$];
    acc_t exp_q[$];
    logic [7:0] tx_bytes [256];

    bit         miso_dead = 1'b0;
    bit         sso = 1'b0;
    bit         roe = 1'b0;
    int         shift_cnt = -1;
    logic [7:0] shift_byte = 8'h00;
    int         cyc = 0;
    int         last_tx_cyc = 0;
    int         ssoff_cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // SPI core model: register effects, loopback shifter, strobe-shape monitor
    initial begin
        int         run;
        bit         active;
        acc_t       cur;
        run = 0;
        cur = '0;
        bus.spi_dataavailable = 1'b0;
        bus.spi_readyfordata  = 1'b1;
        bus.spi_rdata         = 16'h0000;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                bus.spi_dataavailable = 1'b0;
                bus.spi_readyfordata  = 1'b1;
                sso = 1'b0;
                roe = 1'b0;
                run = 0;
                shift_cnt = -1;
            end else begin
                if (shift_cnt > 0) begin
                    shift_cnt--;
                end else if (shift_cnt == 0) begin
                    shift_cnt = -1;
                    bus.spi_readyfordata = 1'b1;
                    if (!miso_dead) begin
                        bus.spi_dataavailable = 1'b1;
                        bus.spi_rdata = {8'($urandom), shift_byte};
                    end
                end
                active = bus.spi_select && (!bus.spi_read_n || !bus.spi_write_n);
                if (bus.spi_select || !bus.spi_read_n || !bus.spi_write_n)
                    check("bus_shape",
                          32'({bus.spi_select, bus.spi_read_n & bus.spi_write_n, bus.spi_read_n | bus.spi_write_n}),
                          32'(3'b101));
                if (active) begin
                    run++;
                    if (run == 1) begin
                        cur = {!bus.spi_write_n, bus.spi_mem_addr, bus.spi_wdata};
                    end else begin
                        check("bus_stable", 32'({!bus.spi_write_n, bus.spi_mem_addr, bus.spi_wdata}), 32'(cur));
                    end
                    if (run == 2) begin
                        obs_q.push_back(cur);
                        if (cur.w) begin
                            case (cur.addr)
                                3'd1: begin
                                    if (bus.spi_dataavailable) roe = 1'b1;
                                    bus.spi_readyfordata = 1'b0;
                                    shift_cnt  = $urandom_range(2, 12);
                                    shift_byte = cur.data[7:0];
                                    last_tx_cyc = cyc;
                                end
                                3'd2: begin
                                    bus.spi_dataavailable = 1'b0;
                                    roe = 1'b0;
                                end
                                3'd3: begin
                                    sso = cur.data[10];
                                    if (!cur.data[10]) ssoff_cyc = cyc;
                                end
                                default: ;
                            endcase
                        end else if (cur.addr == 3'd0) begin
                            bus.spi_dataavailable = 1'b0;
                        end
                    end
                end else if (run > 0) begin
                    check("strobe_len", 32'(run), 32'd2);
                    run = 0;
                end
            end
        end
    end

    task automatic run_txn(input logic [15:0] ss, input int nbytes, input int stall, input bit dead);
        int   n_tx_exp, n_rx_exp, txi, rxi, done_cnt, budget, wait_n, bad_rb, stall_n, obs_at_stall, post, n_cmp;
        bit   tx_fire, rx_fire, err_seen, held;
        logic [7:0] held_data;
        acc_t e, o;

        miso_dead = dead;
        n_tx_exp  = dead ? 1 : nbytes;
        n_rx_exp  = dead ? 0 : nbytes;
        exp_q.delete();
        obs_q.delete();
        exp_q.push_back({1'b1, 3'd2, 16'h0000});
        exp_q.push_back({1'b1, 3'd5, ss});
        exp_q.push_back({1'b1, 3'd3, 16'h0400});
        for (int i = 0; i < n_tx_exp; i++) begin
            exp_q.push_back({1'b1, 3'd1, 8'h00, tx_bytes[i]});
            if (!dead) exp_q.push_back({1'b0, 3'd0, 16'h0000});
        end
        exp_q.push_back({1'b1, 3'd3, 16'h0000});

        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_ss    = ss;
        bus.cmd_len   = 8'(nbytes - 1);
        wait_n = 0;
        while (!bus.cmd_ready && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        check("cmd_accept", 32'(bus.cmd_ready), 32'd1);

        txi = 0; rxi = 0; done_cnt = 0; bad_rb = 0; stall_n = 0; obs_at_stall = -1; post = 0;
        tx_fire = 1'b0; rx_fire = 1'b0; err_seen = 1'b0; held = 1'b0; held_data = 8'h00;
        budget = 1000 + stall + nbytes * 80;
        for (int c = 0; c < budget && post < 3; c++) begin
            @(negedge clk);
            // Command stays offered with junk while busy; it must not be taken again
            if (c == 0) begin
                bus.cmd_ss  = 16'($urandom);
                bus.cmd_len = 8'($urandom);
            end
            if (bus.cmd_ready == bus.busy) bad_rb++;

            if (tx_fire) begin
                txi++;
                bus.tx_valid = 1'b0;
            end
            if (!bus.tx_valid && txi < nbytes && $urandom_range(0, 3) != 0) begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = tx_bytes[txi];
            end
            if (bus.tx_ready && !bus.tx_valid) bad_rb++;
            tx_fire = bus.tx_valid && bus.tx_ready;

            if (rx_fire) rxi++;
            if (stall > 0 && rxi == 0 && bus.rx_valid && stall_n < stall) begin
                if (stall_n == 0) obs_at_stall = obs_q.size();
                stall_n++;
                bus.rx_ready = 1'b0;
            end else begin
                if (obs_at_stall >= 0) begin
                    check("stall_quiet", 32'(obs_q.size()), 32'(obs_at_stall));
                    obs_at_stall = -1;
                end
                bus.rx_ready = ($urandom_range(0, 2) != 0);
            end
            if (held)
                check("rx_hold", 32'({bus.rx_valid, bus.rx_data}), 32'({1'b1, held_data}));
            if (bus.rx_valid && !held) begin
                if (rxi < n_rx_exp) check("rx_data", 32'(bus.rx_data), 32'(tx_bytes[rxi]));
                else check("rx_extra", 32'd1, 32'd0);
            end
            rx_fire   = bus.rx_valid && bus.rx_ready;
            held      = bus.rx_valid && !rx_fire;
            held_data = bus.rx_data;

            if (bus.done) begin
                done_cnt++;
                err_seen = bus.err;
                bus.cmd_valid = 1'b0;
            end
            if (done_cnt > 0) post++;
        end

        check("done_pulse", 32'(done_cnt), 32'd1);
        check("err", 32'(err_seen), 32'(dead));
        check("tx_count", 32'(txi), 32'(n_tx_exp));
        check("rx_count", 32'(rxi), 32'(n_rx_exp));
        check("acc_count", 32'(obs_q.size()), 32'(exp_q.size()));
        n_cmp = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n_cmp; i++) begin
            e = exp_q[i];
            o = obs_q[i];
            if (e.w && e.addr != 3'd2) check("acc", 32'(o), 32'(e));
            else check("acc_kind", 32'({o.w, o.addr}), 32'({e.w, e.addr}));
        end
        check("roe", 32'(roe), 32'd0);
        check("sso_off", 32'(sso), 32'd0);
        check("rdy_busy", 32'(bad_rb), 32'd0);
        check("idle", 32'({bus.cmd_ready, bus.busy, bus.rx_valid}), 32'(3'b100));
        if (dead)
            check("to_window", 32'((ssoff_cyc - last_tx_cyc) >= TO_CYC + 1 && (ssoff_cyc - last_tx_cyc) <= TO_CYC + 8), 32'd1);
        bus.tx_valid  = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.rx_ready  = 1'b0;
        miso_dead     = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_bus"},
              32'({bus.spi_select, bus.spi_read_n, bus.spi_write_n, bus.spi_mem_addr, bus.spi_wdata}),
              32'({1'b0, 1'b1, 1'b1, 3'd0, 16'h0000}));
        check({tag, "_str"},
              32'({bus.rx_valid, bus.rx_data, bus.tx_ready, bus.done, bus.err, bus.busy, bus.cmd_ready}),
              32'({1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}));
    endtask

    task automatic reset_mid_rxw();
        int n;
        obs_q.delete();
        miso_dead = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_ss    = 16'h0004;
        bus.cmd_len   = 8'd3;
        bus.tx_valid  = 1'b1;
        bus.tx_data   = 8'($urandom);
        n = 0;
        while (obs_q.size() < 4 && n < 300) begin
            @(negedge clk);
            if (!bus.cmd_ready) bus.cmd_valid = 1'b0;
            n++;
        end
        check("rst_reach_rxw", 32'(obs_q.size()), 32'd4);
        repeat (10) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("rst_mid");
        bus.tx_valid  = 1'b0;
        bus.cmd_valid = 1'b0;
        miso_dead     = 1'b0;
        @(negedge clk);
        check("rst_ss_n", 32'(!sso), 32'd1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst", 32'({bus.cmd_ready, bus.busy, bus.spi_select}), 32'(3'b100));
        check("post_rst_quiet", 32'(obs_q.size()), 32'd4);
    endtask

    initial begin
        int n;
        bus.cmd_valid = 1'b0;
        bus.cmd_ss    = 16'h0000;
        bus.cmd_len   = 8'h00;
        bus.tx_valid  = 1'b0;
        bus.tx_data   = 8'h00;
        bus.rx_ready  = 1'b0;
        reset_n       = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        tx_bytes[0] = 8'hA5;
        run_txn(16'h0001, 1, 0, 1'b0);

        for (int i = 0; i < 4; i++) tx_bytes[i] = 8'(i + 1);
        run_txn(16'h0002, 4, 0, 1'b0);

        for (int i = 0; i < 3; i++) tx_bytes[i] = 8'($urandom);
        run_txn(16'h8000, 3, 500, 1'b0);

        for (int i = 0; i < 3; i++) tx_bytes[i] = 8'($urandom);
        run_txn(16'h0010, 3, 0, 1'b1);

        reset_mid_rxw();

        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) tx_bytes[i] = 8'($urandom);
            run_txn(16'($urandom), n, ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 40)) : 0, 1'b0);
        end

        for (int i = 0; i < 256; i++) tx_bytes[i] = 8'($urandom);
        run_txn(16'h0001, 256, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
